// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
// Contents: FSM state encoding, default NOP value and the default-width IF/ID payload.
package fetch_pkg;

    localparam int unsigned DEF_ADDR_W  = 16;
    localparam int unsigned DEF_INSTR_W = 16;
    localparam int unsigned DEF_NOP     = 0;

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        STALLED  = 2'd1,
        REDIRECT = 2'd2
    } fetch_state_t;

    // IF/ID pipeline register payload at the default widths
    typedef struct packed {
        logic [DEF_INSTR_W-1:0] instr;
        logic [DEF_ADDR_W-1:0]  pc;
        logic                   valid;
    } if_id_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: synchronous reset to RESET_PC, branch load,
// stall hold, otherwise increment by PC_STEP with natural wrap.
// Ports: clk, reset, load/load_value (redirect), hold (stall), pc (current value).
module fetch_pc_reg #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned PC_STEP  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_value,
    input  logic              hold,
    output logic [ADDR_W-1:0] pc
);

    // Addition truncates to ADDR_W, giving modulo-2^ADDR_W wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= ADDR_W'(RESET_PC);
        end else if (load) begin
            pc <= load_value;
        end else if (!hold) begin
            pc <= pc + ADDR_W'(PC_STEP);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle-latency instruction
// memory and loads the IF/ID register. Handles decode stalls, execute-stage
// redirects with a two-bubble flush, and saturating fetch/flush counters.
// Ports: clk, reset (sync, active high), stall, branch_taken, branch_target,
//        imem_addr (combinational), imem_rdata, instr_out, pc_out, instr_valid,
//        fetch_cnt, flush_cnt.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned INSTR_W  = 16,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned PC_STEP  = 1,
    parameter int unsigned NOP      = DEF_NOP,
    parameter int unsigned CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  pc_out,
    output logic               instr_valid,
    output logic [CNT_W-1:0]   fetch_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    localparam logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP);
    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] req_pc;
    logic              req_valid;
    logic              hold_c;

    // A stall only takes effect when no redirect is pending
    assign hold_c = stall && !branch_taken;

    // While stalled, re-issue the in-flight address so imem_rdata stays stable
    assign imem_addr = hold_c ? req_pc : pc;

    fetch_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_reg (
        .clk        (clk),
        .reset      (reset),
        .load       (branch_taken),
        .load_value (branch_target),
        .hold       (hold_c),
        .pc         (pc)
    );

    // FSM, request tracking, IF/ID register and counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH;
            req_pc      <= '0;
            req_valid   <= 1'b0;
            instr_out   <= NOP_INSTR;
            pc_out      <= '0;
            instr_valid <= 1'b0;
            fetch_cnt   <= '0;
            flush_cnt   <= '0;
        end else if (branch_taken) begin
            state       <= REDIRECT;
            req_valid   <= 1'b0;
            instr_out   <= NOP_INSTR;
            pc_out      <= '0;
            instr_valid <= 1'b0;
            if (flush_cnt != CNT_MAX) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end else if (stall) begin
            state <= STALLED;
        end else begin
            state     <= FETCH;
            req_pc    <= pc;
            req_valid <= 1'b1;
            // REDIRECT always carries req_valid=0, so it emits the second bubble here
            if (state != REDIRECT && req_valid) begin
                instr_out   <= imem_rdata;
                pc_out      <= req_pc;
                instr_valid <= 1'b1;
                if (fetch_cnt != CNT_MAX) begin
                    fetch_cnt <= fetch_cnt + CNT_W'(1);
                end
            end else begin
                instr_out   <= NOP_INSTR;
                pc_out      <= '0;
                instr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch stage for the pipelined CPU. It owns the program counter and drives a synchronous instruction memory. It delivers instructions with their PC and a valid bit into the fetch/decode pipeline register. Beyond a plain PC+1 loop, it supports decode-stage stalls, execute-stage branch redirects with flush, PC wrap-around and saturating performance counters.

## Interface
- ADDR_W, 16, PC / instruction-memory address width
- INSTR_W, 16, instruction width
- RESET_PC, 0, PC value loaded on reset
- PC_STEP, 1, sequential PC increment
- NOP, 0, instruction value driven on instr_out when invalid
- CNT_W, 16, performance counter width
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- stall  in  1  decode hazard: hold PC, in-flight request and IF/ID register
- branch_taken  in  1  execute-stage redirect (NextInstruction select)
- branch_target  in  ADDR_W  redirect address, sampled when branch_taken=1
- imem_addr  out  ADDR_W  instruction memory read address (combinational)
- imem_rdata  in  INSTR_W  memory data; equals mem[imem_addr] one cycle after address presented
- instr_out  out  INSTR_W  IF/ID instruction
- pc_out  out  ADDR_W  PC of instr_out
- instr_valid  out  1  instr_out holds a real instruction
- fetch_cnt  out  CNT_W  instructions delivered valid into IF/ID, saturating
- flush_cnt  out  CNT_W  branch redirects taken, saturating

## Operation
- Internal state:
  - pc: next address to issue.
  - req_pc / req_valid: the request issued last cycle, whose data is on imem_rdata now.
  - FSM state: FETCH, STALLED, REDIRECT.
- imem_addr = req_pc when the next state is STALLED (stall=1 and branch_taken=0); otherwise imem_addr = pc. Re-issuing req_pc keeps imem_rdata stable through the stall.
- Priority: reset > branch_taken > stall > normal.
- **Normal (FETCH, no stall/branch):**
  - pc ← pc+PC_STEP, modulo 2^ADDR_W (wraps from 0xFFFF to 0x0000 at ADDR_W=16).
  - req_pc ← pc; req_valid ← 1.
  - IF/ID ← {imem_rdata, req_pc, req_valid}.
- **stall=1 (no branch):**
  - pc, req_pc, req_valid and IF/ID all hold.
  - FSM → STALLED and stays there while stall=1.
  - On stall=0, FSM → FETCH with normal update that cycle.
- **branch_taken=1 (from any state, including STALLED):**
  - pc ← branch_target; req_valid ← 0.
  - IF/ID ← {NOP, 0, valid=0}.
  - flush_cnt increments.
  - FSM → REDIRECT.
- **REDIRECT:** one bubble cycle.
  - imem_addr = pc (the target); req_pc ← pc; req_valid ← 1; pc ← pc+PC_STEP.
  - IF/ID ← {NOP, 0, valid=0}.
  - Next state: FETCH. If stall=1 in this cycle, the next state is STALLED and the target request is held. If branch_taken=1 again, redirect again.
- **Counters:**
  - fetch_cnt increments on every edge where IF/ID is loaded with valid=1.
  - Both counters saturate at 2^CNT_W−1.
- **Reset values:**
  - pc=RESET_PC; req_pc=0; req_valid=0; state FETCH.
  - instr_out=NOP; pc_out=0; instr_valid=0.
  - fetch_cnt=0; flush_cnt=0.
  - Reset mid-stall or mid-redirect discards all in-flight state.

## Timing
- Memory read latency: 1 cycle (synchronous RAM).
- Sequential latency: address pc presented in cycle N → instr_out/pc_out/instr_valid updated at the edge ending cycle N+1.
- After reset release: first valid instruction (mem[RESET_PC]) appears after 2 edges.
- Redirect latency: branch_taken at edge E → bubbles at E and E+1 → mem[branch_target] valid after edge E+2.
- Stall: an outputs-frozen cycle per stall cycle. No instruction is lost or duplicated across stall entry or exit.
- Throughput: one instruction per cycle in FETCH without stall.
- imem_addr is combinational from state and stall/branch_taken. There is no other combinational input→output path.

## Structure
- Package fetch_pkg:
  - state enum fetch_state_t {FETCH, STALLED, REDIRECT}.
  - default NOP constant.
  - if_id_t struct {instr, pc, valid}.
- Sub-module fetch_pc_reg holds pc with synchronous reset to RESET_PC, load (branch), hold (stall) and increment-with-wrap.
- Top-level fetch_unit contains:
  - the FSM
  - the request-tracking flops
  - the IF/ID register
  - the counters

## Test plan
- Reset then run 5 cycles, mem[i]=0xA000+i → instr_out 0xA000..0xA002 with pc_out 0..2; valid first asserted 2 edges after reset drops.
- stall high 3 cycles while instr_out=0xA003 → outputs frozen at 0xA003/pc 3; after release, next instr_out is 0xA004/pc 4, with no duplicate and no skip.
- branch_taken with target 0x0040 while pc=0x0008 → two invalid NOP cycles, then 0xA040/pc 0x0040; flush_cnt=1.
- branch_taken and stall asserted together → branch wins; target fetched as in the previous test, with no stall effect.
- RESET_PC=0xFFFE → pc_out sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- CNT_W=4, run 20 valid fetches → fetch_cnt saturates at 15. Then assert reset during STALLED → all outputs return to reset values on the next edge.
